bram_search_ctrl: RTL
=====================

Name: bram_search_ctrl

Overview:
Read-side sequencer that sits directly upstream of the 9-entry x 8-bit read-only BRAM block and drives its rd_en/rd_addr port. It consumes the block's data_out/valid_out and binary-searches the memory for a key, assuming ascending contents. It reports hit/miss, the hit address and the probe count, and it times out when the memory never returns valid. It is the search engine for the BRAM-utilisation experiments.

Parameters:
ADDR_W, 4, width of memory address bus
DATA_W, 8, width of memory data / key
DEPTH, 9, number of valid memory entries (addresses 0..DEPTH-1)
TIMEOUT, 8, max cycles spent in WAIT without mem_valid before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin search; sampled only in IDLE
key  in  DATA_W  value to find; latched when start is accepted
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  single-cycle pulse at end of search
found  out  1  1 = key located; valid from done until next start
found_addr  out  ADDR_W  hit address; 0 on miss/error
probes  out  ADDR_W  number of memory reads issued in this search
err  out  1  1 = timeout abort; valid from done until next start
mem_rd_en  out  1  read strobe to BRAM block, one cycle per probe
mem_rd_addr  out  ADDR_W  read address to BRAM block
mem_data  in  DATA_W  BRAM data_out
mem_valid  in  1  BRAM valid_out; BRAM returns it one cycle after sampling rd_en

Behaviour:
- Clocking and reset are as stated in the port list: one clock, synchronous active-high reset.
- While rst is high, the next edge forces state IDLE and clears every output, the key register, lo/hi and the timeout counter to 0. Reset mid-search abandons the search with no done pulse.
- All outputs are registered.
- lo and hi are ADDR_W+1 bits wide, signed, so that hi = -1 is representable. mid = (lo+hi)>>1, computed unsigned, and always lies in 0..DEPTH-1.
- IDLE: on start=1, latch key, lo<=0, hi<=DEPTH-1, probes<=0, found<=0, err<=0, found_addr<=0, busy<=1, go to CHECK. start=0 holds state.
- CHECK: if lo>hi (signed), go to DONE as a miss. Otherwise mem_rd_en<=1, mem_rd_addr<=mid, probes<=probes+1, clear the timeout counter and go to WAIT.
- WAIT: mem_rd_en<=0 on the first WAIT edge, so the strobe is exactly one cycle. mem_rd_addr holds its value.
  - mem_valid=1 and mem_data==key: found<=1, found_addr<=mem_rd_addr, go to DONE.
  - mem_data<key: lo<=mid+1, go to CHECK.
  - mem_data>key: hi<=mid-1, go to CHECK.
  - mem_valid=0: increment the counter. When the counter reaches TIMEOUT, set err<=1 and found<=0, then go to DONE.
- DONE: done=1 for exactly this one cycle; the next edge goes to IDLE with busy<=0 and done<=0. found, found_addr, probes and err hold until the next accepted start.
- Latency, counting edges after the start-sampling edge:
  - Each probe takes 3 edges: CHECK, then BRAM sampling, then valid compare.
  - A hit sets done high after 3*probes edges.
  - A miss sets done high after 3*probes+1 edges.
  - A timeout sets done high after 3*(probes-1)+2+TIMEOUT edges.
- start while busy is ignored; there is no queueing. start asserted in the DONE cycle is also ignored.
- mem_valid arriving outside WAIT is ignored.
- Maximum probes for DEPTH=9 is 4.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> all outputs 0, no mem_rd_en; releasing rst with start low keeps the block in IDLE.
- Hit, middle: BRAM model mem[i]=3i+2 (2,5,...,26), key=17 -> addresses 4,6,5 probed; found=1, found_addr=5, probes=3, err=0; done is one pulse 9 edges after start; mem_rd_en is high exactly 3 single cycles.
- Hit, top edge: same model, key=26 -> addresses 4,6,7,8; found=1, found_addr=8, probes=4. Key=2 -> addresses 4,1,0; found_addr=0, probes=3.
- Miss: key=1 -> addresses 4,1,0, then lo>hi; found=0, found_addr=0, probes=3, done after 10 edges. Key=27 -> probes=4, found=0.
- Timeout: BRAM model never asserts mem_valid, key=5 -> one probe at addr 4; err=1, found=0, probes=1; done after 2+8 edges; busy drops the cycle after done.
- Robustness: pulse start again while busy, and separately assert rst mid-WAIT of a search -> the second start has no effect on probes/result; rst returns to IDLE with no done pulse; a fresh start afterwards yields the correct result.

Source files
------------

// File: rtl/bram_search_ctrl.sv
// rtl/bram_search_ctrl.sv - binary-search read sequencer for a small read-only BRAM
// Probes an ascending memory for a key and reports hit/miss, hit address, probe count and timeout.
module bram_search_ctrl #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 9,
   parameter int TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] key,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [ADDR_W-1:0] found_addr,
   output logic [ADDR_W-1:0] probes,
   output logic              err,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_valid
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic signed [ADDR_W:0] HI_INIT = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic signed [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT, S_DONE} state_t;

   state_t                   state;
   logic [DATA_W-1:0]        key_q;
   logic signed [ADDR_W:0]   lo;
   logic signed [ADDR_W:0]   hi;
   logic [CNT_W-1:0]         tmo_cnt;
   logic [ADDR_W+1:0]        mid_sum;
   logic [ADDR_W-1:0]        mid;
   logic signed [ADDR_W:0]   probe_addr;

   // The sum is only used while lo <= hi, so both operands are non-negative here.
   assign mid_sum    = {1'b0, lo} + {1'b0, hi};
   assign mid        = mid_sum[ADDR_W:1];
   assign probe_addr = $signed({1'b0, mem_rd_addr});

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         key_q       <= '0;
         lo          <= '0;
         hi          <= '0;
         tmo_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         found       <= 1'b0;
         found_addr  <= '0;
         probes      <= '0;
         err         <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  key_q      <= key;
                  lo         <= '0;
                  hi         <= HI_INIT;
                  probes     <= '0;
                  found      <= 1'b0;
                  err        <= 1'b0;
                  found_addr <= '0;
                  busy       <= 1'b1;
                  state      <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (lo > hi) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= mid;
                  probes      <= probes + ADDR_W'(1);
                  tmo_cnt     <= '0;
                  state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               mem_rd_en <= 1'b0;
               if (mem_valid) begin
                  if (mem_data == key_q) begin
                     found      <= 1'b1;
                     found_addr <= mem_rd_addr;
                     done       <= 1'b1;
                     state      <= S_DONE;
                  end else if (mem_data < key_q) begin
                     lo    <= probe_addr + ONE;
                     state <= S_CHECK;
                  end else begin
                     hi    <= probe_addr - ONE;
                     state <= S_CHECK;
                  end
               end else if (tmo_cnt == CNT_W'(TIMEOUT)) begin
                  err   <= 1'b1;
                  found <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
